top_k_tracker: RTL and testbench

//  Streaming rank tracker: keeps the K largest samples seen since reset/clear, sorted descending.
//  Any rank is readable each cycle; rank K-1 (K-th largest) is also on a dedicated output.

---
 rtl/top_k_pkg.sv | 17 +
 rtl/top_k_tracker_if.sv | 14 +
 rtl/top_k_slot.sv | 33 +++
 rtl/top_k_tracker.sv | 67 ++++++
 tb/tb_top_k_tracker.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/top_k_pkg.sv
// top_k_pkg: width helpers and rank comparison shared by the top-K tracker files.
package top_k_pkg;
  localparam int MAX_W = 64;
  function automatic int rank_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction
  function automatic int fill_w(input int k);
    return $clog2(k + 1);
  endfunction
  // Signed compare works by flipping the sign bit, which turns two's complement into offset binary.
  function automatic logic cmp_ge(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                  input logic sgn, input int w);
    logic [MAX_W-1:0] m;
    m = sgn ? (MAX_W'(1) << (w - 1)) : '0;
    return (a ^ m) >= (b ^ m);
  endfunction
endpackage

// File: rtl/top_k_tracker_if.sv
// top_k_tracker_if: sample stream, clear, rank read and fill status for the top-K tracker.
interface top_k_tracker_if #(parameter int DATA_WIDTH = 32, parameter int K = 4);
  import top_k_pkg::*;
  logic [DATA_WIDTH-1:0]  din;
  logic                   din_valid;
  logic                   clear;
  logic [rank_w(K)-1:0]   rd_rank;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic [DATA_WIDTH-1:0]  kth;
  logic [fill_w(K)-1:0]   fill;
  modport master (output din, din_valid, clear, rd_rank, input dout, dout_valid, kth, fill);
  modport slave  (input din, din_valid, clear, rd_rank, output dout, dout_valid, kth, fill);
endinterface

// File: rtl/top_k_slot.sv
// top_k_slot: one rank register holding a value and occupancy, loaded from din or its left neighbour.
module top_k_slot import top_k_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  ins_here,
  input  logic                  shift_in,
  input  logic                  left_occ,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] left_val,
  output logic [DATA_WIDTH-1:0] val,
  output logic                  occ,
  output logic                  ge_din,
  output logic                  eq_din
);
  typedef struct packed {
    logic                  occ;
    logic [DATA_WIDTH-1:0] val;
  } slot_t;
  slot_t q;
  always_ff @(posedge clk)
    if (!resetn) q <= '0;
    else if (ins_here) q <= {1'b1, din};
    else if (shift_in) q <= {left_occ, left_val};
    else if (flush) q <= '0;
  assign val    = q.val;
  assign occ    = q.occ;
  assign ge_din = q.occ && cmp_ge(MAX_W'(q.val), MAX_W'(din), SIGNED_CMP, DATA_WIDTH);
  assign eq_din = q.occ && (q.val == din);
endmodule

// File: rtl/top_k_tracker.sv
// top_k_tracker: keeps the K largest samples seen since reset/clear, sorted descending.
// Define TOP_K_DEDUP_EN to drop samples equal to any tracked value.
module top_k_tracker import top_k_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic             clk,
  input logic             resetn,
  top_k_tracker_if.slave  bus
);
  localparam int FW = fill_w(K);
  logic [DATA_WIDTH-1:0] vals [K];
  logic [K-1:0]          occ, ge, eq, ins, shf;
  logic [FW-1:0]         p, fill_q;
  logic                  dup, accept, rd_ok;
  // Slots are sorted, so ge is a thermometer and p is the first slot below din; clear empties the set.
  always_comb begin
    p = FW'(K);
    for (int i = K - 1; i >= 0; i--)
      if (!ge[i] || bus.clear) p = FW'(i);
  end
`ifdef TOP_K_DEDUP_EN
  assign dup = (|eq) && !bus.clear;
`else
  logic unused_eq;
  assign unused_eq = ^eq;
  assign dup       = 1'b0;
`endif
  assign accept = bus.din_valid && (p != FW'(K)) && !dup;
  for (genvar g = 0; g < K; g++) begin : g_slot
    logic [DATA_WIDTH-1:0] lv;
    logic                  lo;
    if (g == 0) begin : g_first
      assign lv = '0;
      assign lo = 1'b0;
    end else begin : g_rest
      assign lv = vals[g-1];
      assign lo = occ[g-1];
    end
    assign ins[g] = accept && (p == FW'(g));
    assign shf[g] = accept && !bus.clear && (p < FW'(g));
    top_k_slot #(.DATA_WIDTH(DATA_WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (bus.clear),
      .ins_here (ins[g]),
      .shift_in (shf[g]),
      .left_occ (lo),
      .din      (bus.din),
      .left_val (lv),
      .val      (vals[g]),
      .occ      (occ[g]),
      .ge_din   (ge[g]),
      .eq_din   (eq[g])
    );
  end
  always_ff @(posedge clk)
    if (!resetn) fill_q <= '0;
    else if (bus.clear) fill_q <= FW'(accept);
    else if (accept && fill_q != FW'(K)) fill_q <= fill_q + 1'b1;
  assign rd_ok          = FW'(bus.rd_rank) < fill_q;
  assign bus.dout_valid = rd_ok;
  assign bus.dout       = rd_ok ? vals[bus.rd_rank] : '0;
  assign bus.kth        = (fill_q == FW'(K)) ? vals[K-1] : '0;
  assign bus.fill       = fill_q;
endmodule

// File: tb/tb_top_k_tracker.sv
// tb_top_k_tracker: directed checks of an unsigned and a signed K=4, 8-bit tracker.
module tb_top_k_tracker;
  typedef logic [3:0][7:0] vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  top_k_tracker_if #(.DATA_WIDTH(8), .K(4)) u_if ();
  top_k_tracker_if #(.DATA_WIDTH(8), .K(4)) s_if ();
  top_k_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED_CMP(1'b0)) dut_u (.clk(clk), .resetn(resetn), .bus(u_if));
  top_k_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED_CMP(1'b1)) dut_s (.clk(clk), .resetn(resetn), .bus(s_if));

  function automatic vec_t v4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic push_u(input logic [7:0] d);
    u_if.din = d; u_if.din_valid = 1'b1;
    @(posedge clk); #1;
    u_if.din_valid = 1'b0;
  endtask

  task automatic push_s(input logic [7:0] d);
    s_if.din = d; s_if.din_valid = 1'b1;
    @(posedge clk); #1;
    s_if.din_valid = 1'b0;
  endtask

  task automatic read_u(output vec_t v, output logic [3:0] vv);
    for (int i = 0; i < 4; i++) begin
      u_if.rd_rank = 2'(i); #1;
      v[i] = u_if.dout; vv[i] = u_if.dout_valid;
    end
  endtask

  task automatic read_s(output vec_t v, output logic [3:0] vv);
    for (int i = 0; i < 4; i++) begin
      s_if.rd_rank = 2'(i); #1;
      v[i] = s_if.dout; vv[i] = s_if.dout_valid;
    end
  endtask

  task automatic test_reset();
    vec_t v; logic [3:0] vv;
    resetn = 1'b0;
    u_if.din = 8'd200; u_if.din_valid = 1'b1; u_if.clear = 1'b1; u_if.rd_rank = '0;
    s_if.din = 8'h7f;  s_if.din_valid = 1'b1;  s_if.clear = 1'b0;  s_if.rd_rank = '0;
    repeat (2) @(posedge clk);
    #1;
    u_if.din_valid = 1'b0; u_if.clear = 1'b0; s_if.din_valid = 1'b0;
    resetn = 1'b1;
    read_u(v, vv);
    checks++; if (v !== '0) begin errors++; $display("FAIL reset_slots got %h exp %h", v, vec_t'(0)); end
    checks++; if (vv !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", vv); end
    checks++; if (u_if.fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", u_if.fill); end
    checks++; if (u_if.kth !== 8'd0) begin errors++; $display("FAIL reset_kth got %h exp 00", u_if.kth); end
    checks++; if (s_if.fill !== 3'd0) begin errors++; $display("FAIL reset_fill_s got %0d exp 0", s_if.fill); end
  endtask

  task automatic test_fill();
    vec_t v; logic [3:0] vv;
    push_u(8'd5); push_u(8'd9); push_u(8'd2);
    read_u(v, vv);
    checks++; if (v !== v4(9, 5, 2, 0)) begin errors++; $display("FAIL fill_slots got %h exp %h", v, v4(9, 5, 2, 0)); end
    checks++; if (vv !== 4'b0111) begin errors++; $display("FAIL fill_valid got %b exp 0111", vv); end
    checks++; if (u_if.fill !== 3'd3) begin errors++; $display("FAIL fill_count got %0d exp 3", u_if.fill); end
    checks++; if (u_if.kth !== 8'd0) begin errors++; $display("FAIL fill_kth got %h exp 00", u_if.kth); end
  endtask

  task automatic test_full();
    vec_t v; logic [3:0] vv;
    push_u(8'd7);
    read_u(v, vv);
    checks++; if (v !== v4(9, 7, 5, 2)) begin errors++; $display("FAIL full_slots got %h exp %h", v, v4(9, 7, 5, 2)); end
    checks++; if (vv !== 4'b1111) begin errors++; $display("FAIL full_valid got %b exp 1111", vv); end
    checks++; if (u_if.kth !== 8'd2) begin errors++; $display("FAIL full_kth got %h exp 02", u_if.kth); end
    push_u(8'd1);
    read_u(v, vv);
    checks++; if (v !== v4(9, 7, 5, 2)) begin errors++; $display("FAIL drop_slots got %h exp %h", v, v4(9, 7, 5, 2)); end
    checks++; if (u_if.fill !== 3'd4) begin errors++; $display("FAIL drop_fill got %0d exp 4", u_if.fill); end
  endtask

  task automatic test_ties();
    vec_t v, e1, e2; logic [3:0] vv; logic [7:0] k1;
`ifdef TOP_K_DEDUP_EN
    e1 = v4(9, 7, 5, 2); k1 = 8'd2; e2 = v4(9, 8, 7, 5);
`else
    e1 = v4(9, 9, 7, 5); k1 = 8'd5; e2 = v4(9, 9, 8, 7);
`endif
    push_u(8'd9);
    read_u(v, vv);
    checks++; if (v !== e1) begin errors++; $display("FAIL tie_slots got %h exp %h", v, e1); end
    checks++; if (u_if.kth !== k1) begin errors++; $display("FAIL tie_kth got %h exp %h", u_if.kth, k1); end
    push_u(8'd8);
    read_u(v, vv);
    checks++; if (v !== e2) begin errors++; $display("FAIL evict_slots got %h exp %h", v, e2); end
    push_u(8'd7);
    read_u(v, vv);
    checks++; if (v !== e2) begin errors++; $display("FAIL eq_kth_slots got %h exp %h", v, e2); end
    checks++; if (u_if.fill !== 3'd4) begin errors++; $display("FAIL eq_kth_fill got %0d exp 4", u_if.fill); end
  endtask

  task automatic test_clear();
    vec_t v, e; logic [3:0] vv;
`ifdef TOP_K_DEDUP_EN
    e = v4(9, 8, 7, 5);
`else
    e = v4(9, 9, 8, 7);
`endif
    u_if.din = 8'd255; u_if.din_valid = 1'b0;
    @(posedge clk); #1;
    read_u(v, vv);
    checks++; if (v !== e) begin errors++; $display("FAIL novalid_slots got %h exp %h", v, e); end
    u_if.din = 8'd3; u_if.din_valid = 1'b1; u_if.clear = 1'b1;
    @(posedge clk); #1;
    u_if.din_valid = 1'b0; u_if.clear = 1'b0;
    read_u(v, vv);
    checks++; if (v !== v4(3, 0, 0, 0)) begin errors++; $display("FAIL clrins_slots got %h exp %h", v, v4(3, 0, 0, 0)); end
    checks++; if (vv !== 4'b0001) begin errors++; $display("FAIL clrins_valid got %b exp 0001", vv); end
    checks++; if (u_if.fill !== 3'd1) begin errors++; $display("FAIL clrins_fill got %0d exp 1", u_if.fill); end
    checks++; if (u_if.kth !== 8'd0) begin errors++; $display("FAIL clrins_kth got %h exp 00", u_if.kth); end
    u_if.clear = 1'b1;
    @(posedge clk); #1;
    u_if.clear = 1'b0;
    read_u(v, vv);
    checks++; if (vv !== 4'b0000) begin errors++; $display("FAIL clr_valid got %b exp 0000", vv); end
    checks++; if (u_if.fill !== 3'd0) begin errors++; $display("FAIL clr_fill got %0d exp 0", u_if.fill); end
    checks++; if (v !== '0) begin errors++; $display("FAIL clr_slots got %h exp 0", v); end
  endtask

  task automatic test_midreset();
    vec_t v; logic [3:0] vv;
    push_u(8'd4); push_u(8'd6);
    checks++; if (u_if.fill !== 3'd2) begin errors++; $display("FAIL pre_rst_fill got %0d exp 2", u_if.fill); end
    resetn = 1'b0; u_if.din = 8'd200; u_if.din_valid = 1'b1;
    @(posedge clk); #1;
    u_if.rd_rank = 2'd0; #1;
    checks++; if (u_if.fill !== 3'd0) begin errors++; $display("FAIL mid_rst_fill got %0d exp 0", u_if.fill); end
    checks++; if (u_if.dout !== 8'd0 || u_if.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dout got %h/%b exp 00/0", u_if.dout, u_if.dout_valid); end
    resetn = 1'b1; u_if.din_valid = 1'b0;
    @(posedge clk); #1;
    read_u(v, vv);
    checks++; if (v !== '0 || vv !== 4'b0000) begin errors++; $display("FAIL post_rst_slots got %h/%b exp 0/0000", v, vv); end
  endtask

  task automatic test_signed();
    vec_t v; logic [3:0] vv;
    push_s(8'hff); push_s(8'h01); push_s(8'h80);
    read_s(v, vv);
    checks++; if (v !== v4(8'h01, 8'hff, 8'h80, 8'h00)) begin errors++; $display("FAIL signed_slots got %h exp %h", v, v4(8'h01, 8'hff, 8'h80, 8'h00)); end
    checks++; if (s_if.fill !== 3'd3) begin errors++; $display("FAIL signed_fill got %0d exp 3", s_if.fill); end
    s_if.rd_rank = 2'd2; #1;
    checks++; if (s_if.dout !== 8'h80 || s_if.dout_valid !== 1'b1) begin errors++; $display("FAIL signed_rank2 got %h/%b exp 80/1", s_if.dout, s_if.dout_valid); end
    push_s(8'h7f);
    read_s(v, vv);
    checks++; if (v !== v4(8'h7f, 8'h01, 8'hff, 8'h80)) begin errors++; $display("FAIL signed_full got %h exp %h", v, v4(8'h7f, 8'h01, 8'hff, 8'h80)); end
    checks++; if (s_if.kth !== 8'h80) begin errors++; $display("FAIL signed_kth got %h exp 80", s_if.kth); end
    push_u(8'hff); push_u(8'h01); push_u(8'h80);
    read_u(v, vv);
    checks++; if (v !== v4(8'hff, 8'h80, 8'h01, 8'h00)) begin errors++; $display("FAIL unsigned_cmp got %h exp %h", v, v4(8'hff, 8'h80, 8'h01, 8'h00)); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_ties();
    test_clear();
    test_midreset();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
